// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
//   Sequences one vend after the coin FSM issues candy_in: the candy first,
//   then the nickel of change (if owed), then up to two dimes. Each request
//   is a req/ack handshake with a one-cycle all-low gap between handshakes.
//   A request that goes unacknowledged for ACK_TIMEOUT cycles parks the
//   controller in a sticky FAULT state that only reset leaves.
//
// Parameters
//   ACK_TIMEOUT  cycles a request may stay high without its ack (1..255)
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous, active-low reset
//   candy_in    in   one-cycle vend command
//   nickel_in   in   one nickel of change owed (valid with candy_in)
//   dime_in     in   thermometer dime count 00/01/11 (valid with candy_in)
//   candy_ack   in   candy dispenser done
//   coin_ack    in   coin hopper done
//   candy_req   out  candy dispenser request
//   coin_req    out  coin hopper request
//   coin_sel    out  hopper select, 0 nickel / 1 dime (valid with coin_req)
//   thanks_out  out  one-cycle pulse returning the coin FSM to idle
//   busy        out  high in every state except IDLE and FAULT
//   fault       out  sticky ack-timeout indication
// ---------------------------------------------------------------------------
module vend_dispense_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       candy_in,
  input  logic       nickel_in,
  input  logic [1:0] dime_in,
  input  logic       candy_ack,
  input  logic       coin_ack,
  output logic       candy_req,
  output logic       coin_req,
  output logic       coin_sel,
  output logic       thanks_out,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CANDY  = 3'd1,
    GAP    = 3'd2,
    NICKEL = 3'd3,
    DIME   = 3'd4,
    THANKS = 3'd5,
    FAULT  = 3'd6
  } state_t;

  // The wait that ends with the timer at this value is the last one allowed;
  // an ack in that same cycle still counts as normal progress.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] TIMEOUT_FULL = 8'(ACK_TIMEOUT);

  state_t     state_reg;
  logic [7:0] timer_reg;
  logic       nick_cnt_reg;
  logic [1:0] dime_cnt_reg;

  // Only the ack that matches the currently raised request is honoured.
  logic cur_ack;
  always_comb begin
    cur_ack = 1'b0;
    if (state_reg == CANDY)
      cur_ack = candy_ack;
    else if (state_reg == NICKEL || state_reg == DIME)
      cur_ack = coin_ack;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      timer_reg    <= 8'd0;
      nick_cnt_reg <= 1'b0;
      dime_cnt_reg <= 2'd0;
      candy_req    <= 1'b0;
      coin_req     <= 1'b0;
      coin_sel     <= 1'b0;
      thanks_out   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      thanks_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (candy_in) begin
            nick_cnt_reg <= nickel_in;
            // Thermometer code summed bitwise so 10 also counts as one dime.
            dime_cnt_reg <= {1'b0, dime_in[0]} + {1'b0, dime_in[1]};
            timer_reg    <= 8'd0;
            candy_req    <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= CANDY;
          end
        end

        CANDY, NICKEL, DIME: begin
          if (cur_ack) begin
            candy_req <= 1'b0;
            coin_req  <= 1'b0;
            coin_sel  <= 1'b0;
            state_reg <= GAP;
            if (state_reg == NICKEL)
              nick_cnt_reg <= 1'b0;
            if (state_reg == DIME && dime_cnt_reg != 2'd0)
              dime_cnt_reg <= dime_cnt_reg - 2'd1;
          end else if (timer_reg == TIMEOUT_LAST) begin
            timer_reg <= TIMEOUT_FULL;
            candy_req <= 1'b0;
            coin_req  <= 1'b0;
            coin_sel  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b1;
            state_reg <= FAULT;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        GAP: begin
          if (nick_cnt_reg) begin
            timer_reg <= 8'd0;
            coin_req  <= 1'b1;
            coin_sel  <= 1'b0;
            state_reg <= NICKEL;
          end else if (dime_cnt_reg != 2'd0) begin
            timer_reg <= 8'd0;
            coin_req  <= 1'b1;
            coin_sel  <= 1'b1;
            state_reg <= DIME;
          end else begin
            thanks_out <= 1'b1;
            state_reg  <= THANKS;
          end
        end

        THANKS: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        FAULT: begin
          // Sticky until reset.
          state_reg <= FAULT;
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
